// File: rtl/memory_stage_if.sv
// Data-bus request/response bundle between the MEM stage (master) and the memory system.
interface memory_stage_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline record types shared by the core, and the MEM stage: issues loads/stores
// on the data bus, stalls the front of the pipe while waiting, formats load data for WB.
package common;
  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;
endpackage

package pipes;
  import common::*;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic csrwrite;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    word_t       pc;
    logic [31:0] instr;
    ctl_t        ctl;
    creg_addr_t  dst;
    logic [11:0] csrdst;
    word_t       csr;
    logic        error;
    word_t       result;
    word_t       rd2;
  } excute_data_t;

  typedef struct packed {
    logic        valid;
    word_t       pc;
    logic [31:0] instr;
    ctl_t        ctl;
    creg_addr_t  dst;
    logic [11:0] csrdst;
    word_t       csr;
    logic        error;
    word_t       addr;
    word_t       result;
  } memory_data_t;

  typedef struct packed {
    logic       ismem;
    creg_addr_t dst;
    word_t      data;
  } tran_t;
endpackage

module memory_stage
  import common::*;
  import pipes::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  excute_data_t        in,
  output logic                stall,
  output memory_data_t        out,
  output tran_t               fwd,
  output logic                misalign,
  memory_stage_if.master      dbus
);

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA} state_t;

  state_t       state, state_n;
  excute_data_t cur;
  logic [2:0]   f3;
  logic [2:0]   a;
  logic         is_load, is_store, is_mem, aligned, memreq, done;
  word_t        shifted, ldata;

  assign f3       = cur.instr[14:12];
  assign a        = cur.result[2:0];
  assign is_load  = (cur.instr[6:0] == 7'b0000011);
  assign is_store = (cur.instr[6:0] == 7'b0100011);
  assign is_mem   = is_load | is_store;

  always_comb begin
    aligned = 1'b1;
    unique case (f3[1:0])
      2'd0: aligned = 1'b1;
      2'd1: aligned = ~a[0];
      2'd2: aligned = (a[1:0] == 2'b00);
      2'd3: aligned = (a == 3'b000);
    endcase
  end

  assign memreq   = cur.valid & is_mem & aligned;
  assign misalign = cur.valid & is_mem & ~aligned;

  // memreq is a pure function of cur, which is frozen while stalled, so the
  // request and its fields stay stable until the data_ok cycle.
  assign dbus.dreq_valid = memreq;
  assign dbus.dreq_addr  = cur.result;
  assign dbus.dreq_size  = {1'b0, f3[1:0]};
  assign dbus.dreq_data  = cur.rd2 << {a, 3'b000};

  always_comb begin
    dbus.dreq_strobe = '0;
    if (is_store) begin
      unique case (f3[1:0])
        2'd0: dbus.dreq_strobe = 8'h01 << a;
        2'd1: dbus.dreq_strobe = 8'h03 << a;
        2'd2: dbus.dreq_strobe = 8'h0F << a;
        2'd3: dbus.dreq_strobe = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (memreq) begin
          if (dbus.dresp_addr_ok && dbus.dresp_data_ok) done = 1'b1;
          else if (dbus.dresp_addr_ok)                  state_n = WAIT_DATA;
          else                                          state_n = WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        if (dbus.dresp_addr_ok) begin
          if (dbus.dresp_data_ok) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (dbus.dresp_data_ok) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign stall = memreq & ~done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  assign shifted = dbus.dresp_data >> {a, 3'b000};

  always_comb begin
    ldata = shifted;
    unique case (f3)
      3'b000:  ldata = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ldata = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ldata = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ldata = {56'd0, shifted[7:0]};
      3'b101:  ldata = {48'd0, shifted[15:0]};
      3'b110:  ldata = {32'd0, shifted[31:0]};
      default: ldata = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     cur <= '0;
    else if (!stall) cur <= in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out <= '0;
    end else if (stall) begin
      out.valid <= 1'b0;
    end else begin
      out.valid        <= cur.valid;
      out.pc           <= cur.pc;
      out.instr        <= cur.instr;
      out.ctl          <= cur.ctl;
      out.ctl.regwrite <= cur.ctl.regwrite & ~misalign;
      out.dst          <= cur.dst;
      out.csrdst       <= cur.csrdst;
      out.csr          <= cur.csr;
      out.error        <= cur.error;
      out.addr         <= cur.result;
      out.result       <= (is_load && aligned) ? ldata : cur.result;
    end
  end

  always_comb begin
    fwd       = '0;
    fwd.ismem = is_load;
    fwd.dst   = (cur.valid && cur.ctl.regwrite) ? cur.dst : '0;
    fwd.data  = cur.result;
  end

endmodule
